cnn_tile_sched: RTL and testbench

Tile-loop scheduler for the CNN convolution engine. On `start_i` it walks the tiled convolution loop nest over output maps (step `Tm_p`), output rows and columns, input maps (step `Tn_p`) and kernel rows and columns. It issues one command per innermost iteration over a valid/ready handshake. It sits between the top-level control and the `cnn` compute datapath, replacing the single `valid_i` pulse with a sequenced command stream.

---
 rtl/cnn_tile_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_cnn_tile_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_tile_sched.sv
// Tile-loop scheduler: walks the m/r/c/n/i/j convolution loop nest and issues one registered command per handshake.
// Optional backpressure counter on perf_stall_o is built when CNN_SCHED_PERF_EN is defined.
module cnn_tile_sched #(
  parameter int N_p  = 1,
  parameter int M_p  = 1,
  parameter int K_p  = 1,
  parameter int R_p  = 4,
  parameter int C_p  = 4,
  parameter int S_p  = 1,
  parameter int Tn_p = 1,
  parameter int Tm_p = 1,
  localparam int MW  = (M_p > 1) ? $clog2(M_p) : 1,
  localparam int NW  = (N_p > 1) ? $clog2(N_p) : 1,
  localparam int RW  = (R_p > 1) ? $clog2(R_p) : 1,
  localparam int CW  = (C_p > 1) ? $clog2(C_p) : 1,
  localparam int KW  = (K_p > 1) ? $clog2(K_p) : 1,
  localparam int MLW = $clog2(Tm_p + 1),
  localparam int NLW = $clog2(Tn_p + 1),
  localparam int IRS = (R_p - 1) * S_p + K_p,
  localparam int ICS = (C_p - 1) * S_p + K_p,
  localparam int IRW = (IRS > 1) ? $clog2(IRS) : 1,
  localparam int ICW = (ICS > 1) ? $clog2(ICS) : 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           cmd_v_o,
  input  logic           cmd_ready_i,
  output logic [MW-1:0]  m_o,
  output logic [MLW-1:0] m_len_o,
  output logic [NW-1:0]  n_o,
  output logic [NLW-1:0] n_len_o,
  output logic [RW-1:0]  r_o,
  output logic [CW-1:0]  c_o,
  output logic [IRW-1:0] in_row_o,
  output logic [ICW-1:0] in_col_o,
  output logic           first_o,
  output logic           last_o,
  input  logic           engine_idle_i,
  output logic [31:0]    perf_stall_o
);

  // Handshake: a command transfers on a rising edge where cmd_v_o & cmd_ready_i;
  // once raised, cmd_v_o and all command fields hold until that transfer.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [MW-1:0] m_q, m_d;
  logic [NW-1:0] n_q, n_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [KW-1:0] i_q, i_d;
  logic [KW-1:0] j_q, j_d;

  logic [MW-1:0]  m_out_q, m_out_d;
  logic [MLW-1:0] m_len_q, m_len_d;
  logic [NW-1:0]  n_out_q, n_out_d;
  logic [NLW-1:0] n_len_q, n_len_d;
  logic [RW-1:0]  r_out_q, r_out_d;
  logic [CW-1:0]  c_out_q, c_out_d;
  logic [IRW-1:0] in_row_q, in_row_d;
  logic [ICW-1:0] in_col_q, in_col_d;
  logic           first_q, first_d;
  logic           last_q, last_d;

  logic hs;
  logic j_wrap, i_wrap, n_wrap, c_wrap, r_wrap, m_wrap;
  logic cy_i, cy_n, cy_c, cy_r, cy_m, last_cmd;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (hs && last_cmd) state_d = S_DRAIN;
      S_DRAIN: if (engine_idle_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
    cmd_v_o = (state_q == S_RUN);
  end

  assign hs = cmd_v_o & cmd_ready_i;

  // Carry chain: each loop level wraps only when every inner level wraps.
  always_comb begin
    j_wrap   = (int'(j_q) == K_p - 1);
    i_wrap   = (int'(i_q) == K_p - 1);
    n_wrap   = (int'(n_q) + Tn_p >= N_p);
    c_wrap   = (int'(c_q) == C_p - 1);
    r_wrap   = (int'(r_q) == R_p - 1);
    m_wrap   = (int'(m_q) + Tm_p >= M_p);
    cy_i     = j_wrap;
    cy_n     = cy_i & i_wrap;
    cy_c     = cy_n & n_wrap;
    cy_r     = cy_c & c_wrap;
    cy_m     = cy_r & r_wrap;
    last_cmd = cy_m & m_wrap;
  end

  always_comb begin
    m_d = m_q;
    n_d = n_q;
    r_d = r_q;
    c_d = c_q;
    i_d = i_q;
    j_d = j_q;
    if (state_q == S_IDLE) begin
      m_d = '0;
      n_d = '0;
      r_d = '0;
      c_d = '0;
      i_d = '0;
      j_d = '0;
    end else if (hs) begin
      j_d = j_wrap ? '0 : j_q + 1'b1;
      if (cy_i) i_d = i_wrap ? '0 : i_q + 1'b1;
      if (cy_n) n_d = n_wrap ? '0 : n_q + NW'(Tn_p);
      if (cy_c) c_d = c_wrap ? '0 : c_q + 1'b1;
      if (cy_r) r_d = r_wrap ? '0 : r_q + 1'b1;
      if (cy_m) m_d = m_wrap ? '0 : m_q + MW'(Tm_p);
    end
  end

  // Command fields are derived from the next counter values so they are registered outputs.
  always_comb begin
    logic run_d;
    int   m_rem;
    int   n_rem;
    run_d    = (state_d == S_RUN);
    m_rem    = M_p - int'(m_d);
    n_rem    = N_p - int'(n_d);
    m_out_d  = run_d ? m_d : '0;
    n_out_d  = run_d ? n_d : '0;
    r_out_d  = run_d ? r_d : '0;
    c_out_d  = run_d ? c_d : '0;
    m_len_d  = run_d ? MLW'((m_rem < Tm_p) ? m_rem : Tm_p) : '0;
    n_len_d  = run_d ? NLW'((n_rem < Tn_p) ? n_rem : Tn_p) : '0;
    in_row_d = run_d ? IRW'(int'(r_d) * S_p + int'(i_d)) : '0;
    in_col_d = run_d ? ICW'(int'(c_d) * S_p + int'(j_d)) : '0;
    first_d  = run_d & (n_d == '0) & (i_d == '0) & (j_d == '0);
    last_d   = run_d & (int'(n_d) + Tn_p >= N_p) & (int'(i_d) == K_p - 1)
             & (int'(j_d) == K_p - 1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      m_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      m_out_q  <= '0;
      m_len_q  <= '0;
      n_out_q  <= '0;
      n_len_q  <= '0;
      r_out_q  <= '0;
      c_out_q  <= '0;
      in_row_q <= '0;
      in_col_q <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      m_q      <= m_d;
      n_q      <= n_d;
      r_q      <= r_d;
      c_q      <= c_d;
      i_q      <= i_d;
      j_q      <= j_d;
      m_out_q  <= m_out_d;
      m_len_q  <= m_len_d;
      n_out_q  <= n_out_d;
      n_len_q  <= n_len_d;
      r_out_q  <= r_out_d;
      c_out_q  <= c_out_d;
      in_row_q <= in_row_d;
      in_col_q <= in_col_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  assign m_o      = m_out_q;
  assign m_len_o  = m_len_q;
  assign n_o      = n_out_q;
  assign n_len_o  = n_len_q;
  assign r_o      = r_out_q;
  assign c_o      = c_out_q;
  assign in_row_o = in_row_q;
  assign in_col_o = in_col_q;
  assign first_o  = first_q;
  assign last_o   = last_q;

`ifdef CNN_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Saturating stall counter; cleared when a new job is accepted.
  always_ff @(posedge clk_i) begin
    if (!reset_i)                                       perf_q <= '0;
    else if (state_q == S_IDLE && start_i)              perf_q <= '0;
    else if (cmd_v_o && !cmd_ready_i && perf_q != '1)   perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_cnn_tile_sched.sv
// Directed bench for cnn_tile_sched: three parameter sets share clock, reset, ready and engine-idle.
// Expected command streams come from a nested-loop reference model pushed into per-instance queues.
module tb_cnn_tile_sched;

  logic clk;
  logic rst_n;
  logic ready;
  logic eidle;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];
  logic [63:0] exp_c_q[$];

  // Instance A: N=M=K=1, R=C=4, S=1, Tn=Tm=1
  logic a_start, a_busy, a_done, a_v, a_first, a_last;
  logic [0:0] a_m, a_ml, a_n, a_nl;
  logic [1:0] a_r, a_c, a_ir, a_ic;
  logic [31:0] a_perf;

  // Instance B: N=3, M=5, K=3, R=C=4, S=1, Tn=Tm=2
  logic b_start, b_busy, b_done, b_v, b_first, b_last;
  logic [2:0] b_m;
  logic [1:0] b_ml, b_n, b_nl, b_r, b_c;
  logic [2:0] b_ir, b_ic;
  logic [31:0] b_perf;

  // Instance C: N=M=1, K=3, R=C=2, S=2, Tn=Tm=1
  logic c_start, c_busy, c_done, c_v, c_first, c_last;
  logic [0:0] c_m, c_ml, c_n, c_nl, c_r, c_c;
  logic [2:0] c_ir, c_ic;
  logic [31:0] c_perf;

  cnn_tile_sched #(.N_p(1), .M_p(1), .K_p(1), .R_p(4), .C_p(4), .S_p(1), .Tn_p(1), .Tm_p(1)) u_a (
    .clk_i(clk), .reset_i(rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .cmd_v_o(a_v), .cmd_ready_i(ready), .m_o(a_m), .m_len_o(a_ml), .n_o(a_n), .n_len_o(a_nl),
    .r_o(a_r), .c_o(a_c), .in_row_o(a_ir), .in_col_o(a_ic), .first_o(a_first), .last_o(a_last),
    .engine_idle_i(eidle), .perf_stall_o(a_perf));

  cnn_tile_sched #(.N_p(3), .M_p(5), .K_p(3), .R_p(4), .C_p(4), .S_p(1), .Tn_p(2), .Tm_p(2)) u_b (
    .clk_i(clk), .reset_i(rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .cmd_v_o(b_v), .cmd_ready_i(ready), .m_o(b_m), .m_len_o(b_ml), .n_o(b_n), .n_len_o(b_nl),
    .r_o(b_r), .c_o(b_c), .in_row_o(b_ir), .in_col_o(b_ic), .first_o(b_first), .last_o(b_last),
    .engine_idle_i(eidle), .perf_stall_o(b_perf));

  cnn_tile_sched #(.N_p(1), .M_p(1), .K_p(3), .R_p(2), .C_p(2), .S_p(2), .Tn_p(1), .Tm_p(1)) u_c (
    .clk_i(clk), .reset_i(rst_n), .start_i(c_start), .busy_o(c_busy), .done_o(c_done),
    .cmd_v_o(c_v), .cmd_ready_i(ready), .m_o(c_m), .m_len_o(c_ml), .n_o(c_n), .n_len_o(c_nl),
    .r_o(c_r), .c_o(c_c), .in_row_o(c_ir), .in_col_o(c_ic), .first_o(c_first), .last_o(c_last),
    .engine_idle_i(eidle), .perf_stall_o(c_perf));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int m, input int ml, input int n, input int nl,
                                       input int r, input int c, input int ir, input int ic,
                                       input int f, input int l);
    return {14'd0, 6'(m), 6'(ml), 6'(n), 6'(nl), 6'(r), 6'(c), 6'(ir), 6'(ic), 1'(f), 1'(l)};
  endfunction

  // Reference model: straight nested loops in the documented order
  task automatic gen(input int sel, input int N, input int M, input int K, input int R,
                     input int C, input int S, input int Tn, input int Tm);
    logic [63:0] w;
    for (int m = 0; m < M; m += Tm)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          for (int n = 0; n < N; n += Tn)
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++) begin
                w = pack(m, (M - m < Tm) ? M - m : Tm, n, (N - n < Tn) ? N - n : Tn, r, c,
                         r * S + i, c * S + j, int'(n == 0 && i == 0 && j == 0),
                         int'(n + Tn >= N && i == K - 1 && j == K - 1));
                case (sel)
                  0:       exp_a_q.push_back(w);
                  1:       exp_b_q.push_back(w);
                  default: exp_c_q.push_back(w);
                endcase
              end
  endtask

  logic [63:0] a_w, b_w, c_w;
  assign a_w = pack(int'(a_m), int'(a_ml), int'(a_n), int'(a_nl), int'(a_r), int'(a_c),
                    int'(a_ir), int'(a_ic), int'(a_first), int'(a_last));
  assign b_w = pack(int'(b_m), int'(b_ml), int'(b_n), int'(b_nl), int'(b_r), int'(b_c),
                    int'(b_ir), int'(b_ic), int'(b_first), int'(b_last));
  assign c_w = pack(int'(c_m), int'(c_ml), int'(c_n), int'(c_nl), int'(c_r), int'(c_c),
                    int'(c_ir), int'(c_ic), int'(c_first), int'(c_last));

  // Scoreboards: sampled 1 time unit after the falling edge, once the drivers have settled
  int a_hs_cnt = 0;
  int a_stall_cnt = 0;
  logic a_prev_stall = 1'b0;
  logic [63:0] a_prev_w = '0;

  always begin
    @(negedge clk);
    #1;
    if (rst_n && a_prev_stall) begin
      check("a_stall_valid", 64'(a_v), 64'd1);
      check("a_stall_hold", a_w, a_prev_w);
    end
    if (rst_n && a_v && ready) begin
      check("a_q_nonempty", 64'(exp_a_q.size() != 0), 64'd1);
      if (exp_a_q.size() != 0) check("a_cmd", a_w, exp_a_q.pop_front());
      a_hs_cnt++;
    end
    if (rst_n && a_v && !ready) a_stall_cnt++;
    a_prev_stall = rst_n && a_v && !ready;
    a_prev_w     = a_w;
  end

  int b_hs_cnt = 0;
  int b_last_cnt = 0;
  int b_wb_maps = 0;
  int b_max_row = 0;
  int b_prev_m = 0;
  int b_mlen_q[$];
  int b_nl_at[3];
  logic b_done_seen = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (rst_n && b_v && ready) begin
      check("b_q_nonempty", 64'(exp_b_q.size() != 0), 64'd1);
      if (exp_b_q.size() != 0) check("b_cmd", b_w, exp_b_q.pop_front());
      if (b_hs_cnt == 0 || int'(b_m) != b_prev_m) b_mlen_q.push_back(int'(b_ml));
      b_prev_m = int'(b_m);
      if (b_hs_cnt % 9 == 0 && b_hs_cnt < 27) b_nl_at[b_hs_cnt / 9] = int'(b_nl);
      if (b_last) begin
        b_last_cnt++;
        b_wb_maps += int'(b_ml);
      end
      if (int'(b_ir) > b_max_row) b_max_row = int'(b_ir);
      b_hs_cnt++;
    end
    if (b_done) b_done_seen = 1'b1;
  end

  int c_hs_cnt = 0;
  int c_max_row = 0;
  int c_max_col = 0;
  int c_min_row = 99;
  int c_min_col = 99;
  int c_spot_row = -1;
  int c_spot_col = -1;
  logic c_done_seen = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (rst_n && c_v && ready) begin
      check("c_q_nonempty", 64'(exp_c_q.size() != 0), 64'd1);
      if (exp_c_q.size() != 0) check("c_cmd", c_w, exp_c_q.pop_front());
      if (int'(c_ir) > c_max_row) c_max_row = int'(c_ir);
      if (int'(c_ic) > c_max_col) c_max_col = int'(c_ic);
      if (int'(c_ir) < c_min_row) c_min_row = int'(c_ir);
      if (int'(c_ic) < c_min_col) c_min_col = int'(c_ic);
      // index 33 is r=1, c=1, i=2, j=0 in raster order over (r, c, i, j)
      if (c_hs_cnt == 33) begin
        c_spot_row = int'(c_ir);
        c_spot_col = int'(c_ic);
      end
      c_hs_cnt++;
    end
    if (c_done) c_done_seen = 1'b1;
  end

  // Driver: one 16-command job on instance A
  task automatic run_a(input bit rand_ready, input bit mid_start, input bit idle_delay,
                       input int exp_lat);
    int lat;
    int idle_low;
    exp_a_q.delete();
    gen(0, 1, 1, 1, 4, 4, 1, 1, 1);
    a_hs_cnt    = 0;
    a_stall_cnt = 0;
    idle_low    = 0;
    @(negedge clk);
    a_start = 1'b1;
    ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    lat     = 1;
    while (!a_done && lat < 2000) begin
      @(negedge clk);
      a_start = 1'b0;
      lat++;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_start && lat == 5) a_start = 1'b1;
      if (idle_delay && a_busy && !a_v) begin
        if (idle_low < 10) begin
          eidle = 1'b0;
          idle_low++;
        end else begin
          eidle = 1'b1;
        end
      end
    end
    check("a_done_seen", 64'(a_done), 64'd1);
    if (exp_lat > 0) check("a_latency", 64'(lat), 64'(exp_lat));
    check("a_cmd_count", 64'(a_hs_cnt), 64'd16);
    check("a_q_drained", 64'(exp_a_q.size()), 64'd0);
`ifdef CNN_SCHED_PERF_EN
    check("a_perf_stall", 64'(a_perf), 64'(a_stall_cnt));
`else
    check("a_perf_stall", 64'(a_perf), 64'd0);
`endif
    ready = 1'b1;
    eidle = 1'b1;
    @(negedge clk);
    check("a_done_pulse", 64'(a_done), 64'd0);
    check("a_busy_after", 64'(a_busy), 64'd0);
  endtask

  initial begin
    int guard;
    rst_n   = 1'b0;
    ready   = 1'b1;
    eidle   = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_done", 64'(a_done), 64'd0);
    check("rst_a_valid", 64'(a_v), 64'd0);
    check("rst_a_fields", a_w, 64'd0);
    check("rst_a_perf", 64'(a_perf), 64'd0);
    check("rst_b_valid", 64'(b_v), 64'd0);
    check("rst_b_fields", b_w, 64'd0);
    check("rst_c_fields", c_w, 64'd0);
    rst_n = 1'b1;

    // Raster walk, always ready and idle: done 19 cycles counting the start cycle
    run_a(1'b0, 1'b0, 1'b0, 19);

    // Tiled job with partial tiles on B, strided job on C, run together
    exp_b_q.delete();
    exp_c_q.delete();
    gen(1, 3, 5, 3, 4, 4, 1, 2, 2);
    gen(2, 1, 1, 3, 2, 2, 2, 1, 1);
    @(negedge clk);
    b_start = 1'b1;
    c_start = 1'b1;
    ready   = 1'b1;
    guard   = 0;
    @(negedge clk);
    b_start = 1'b0;
    c_start = 1'b0;
    while (!(b_done_seen && c_done_seen) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("b_done_seen", 64'(b_done_seen), 64'd1);
    check("c_done_seen", 64'(c_done_seen), 64'd1);
    check("b_cmd_count", 64'(b_hs_cnt), 64'd864);
    check("b_q_drained", 64'(exp_b_q.size()), 64'd0);
    // one write-back per (m tile, pixel): 3 * 16; maps written back: 5 * 16
    check("b_last_pulses", 64'(b_last_cnt), 64'd48);
    check("b_wb_maps", 64'(b_wb_maps), 64'd80);
    check("b_mlen_tiles", 64'(b_mlen_q.size()), 64'd3);
    if (b_mlen_q.size() == 3) begin
      check("b_mlen_0", 64'(b_mlen_q[0]), 64'd2);
      check("b_mlen_1", 64'(b_mlen_q[1]), 64'd2);
      check("b_mlen_2", 64'(b_mlen_q[2]), 64'd1);
    end
    check("b_nlen_0", 64'(b_nl_at[0]), 64'd2);
    check("b_nlen_1", 64'(b_nl_at[1]), 64'd1);
    check("b_nlen_2", 64'(b_nl_at[2]), 64'd2);
    check("b_in_row_max", 64'(b_max_row), 64'd5);
    check("c_cmd_count", 64'(c_hs_cnt), 64'd36);
    check("c_q_drained", 64'(exp_c_q.size()), 64'd0);
    check("c_in_row_max", 64'(c_max_row), 64'd4);
    check("c_in_col_max", 64'(c_max_col), 64'd4);
    check("c_in_row_min", 64'(c_min_row), 64'd0);
    check("c_in_col_min", 64'(c_min_col), 64'd0);
    check("c_spot_row", 64'(c_spot_row), 64'd4);
    check("c_spot_col", 64'(c_spot_col), 64'd2);

    // 50% random ready on A: same stream, outputs held while stalled
    run_a(1'b1, 1'b0, 1'b0, 0);

    // Start pulse mid-run is ignored; engine busy 10 extra cycles delays done by 10
    run_a(1'b0, 1'b1, 1'b1, 29);

    // Reset while command 7 is presented, then a clean replay from command 0
    exp_a_q.delete();
    gen(0, 1, 1, 1, 4, 4, 1, 1, 1);
    a_hs_cnt = 0;
    @(negedge clk);
    a_start = 1'b1;
    ready   = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    guard   = 0;
    while (a_hs_cnt < 7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(a_v), 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    check("mid_rst_fields", a_w, 64'd0);
    check("mid_rst_perf", 64'(a_perf), 64'd0);
    check("mid_rst_count", 64'(a_hs_cnt), 64'd7);
    rst_n = 1'b1;
    run_a(1'b0, 1'b0, 1'b0, 19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
